// File: rtl/stack_engine_pkg.sv
// Shared definitions for the stack engine: opcodes, completion codes, FSM states
// and the per-opcode operand and growth rules.
package stack_engine_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_PUSH  = 4'd1,
    OP_POP   = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_MUL   = 4'd5,
    OP_DIV   = 4'd6,
    OP_DUP   = 4'd7,
    OP_ROT   = 4'd8,
    OP_SWAP  = 4'd9,
    OP_OVER  = 4'd10,
    OP_DROP  = 4'd11,
    OP_DEPTH = 4'd12,
    OP_MOD   = 4'd13
  } opcode_t;

  localparam int OP_LAST = 13;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_INVALID   = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd3;
  localparam logic [2:0] ERR_DIV_ZERO  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Number of stack entries an opcode consumes as operands.
  function automatic logic [1:0] op_need(opcode_t op);
    case (op)
      OP_POP, OP_DUP, OP_DROP:                             op_need = 2'd1;
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_SWAP,
      OP_OVER:                                             op_need = 2'd2;
      OP_ROT:                                              op_need = 2'd3;
      default:                                             op_need = 2'd0;
    endcase
  endfunction

  // Opcodes that leave the stack one entry deeper.
  function automatic logic op_grows(opcode_t op);
    op_grows = (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER) || (op == OP_DEPTH);
  endfunction

endpackage

// File: rtl/stack_engine_seq_divider.sv
// Restoring unsigned divider, one quotient bit per enabled cycle, DATA cycles per divide.
// quotient/remainder show the final-step result in the cycle where done is high.
module seq_divider #(
  parameter int DATA = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            en,
  input  logic            start,
  input  logic [DATA-1:0] dividend,
  input  logic [DATA-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [DATA-1:0] quotient,
  output logic [DATA-1:0] remainder
);

  localparam int CW = $clog2(DATA + 1);

  logic [DATA-1:0] rem_q;
  logic [DATA-1:0] quo_q;
  logic [DATA-1:0] dvs_q;
  logic [CW-1:0]   cnt_q;

  logic [DATA:0]   partial;
  logic            fits;
  logic [DATA-1:0] rem_n;
  logic [DATA-1:0] quo_n;

  // Shift the next dividend bit into the partial remainder and try the subtraction.
  assign partial = {rem_q, quo_q[DATA-1]};
  assign fits    = partial >= {1'b0, dvs_q};
  assign rem_n   = fits ? (partial[DATA-1:0] - dvs_q) : partial[DATA-1:0];
  assign quo_n   = {quo_q[DATA-2:0], fits};

  assign quotient  = quo_n;
  assign remainder = rem_n;
  assign done      = busy && en && (cnt_q == CW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CW'(DATA);
      busy  <= 1'b1;
    end else if (busy && en) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/stack_engine.sv
// Stack-machine execution engine: accepts one command at a time, updates a register-array
// data stack and reports a one-cycle completion pulse with result and status.
module stack_engine
  import stack_engine_pkg::*;
#(
  parameter int DATA   = 32,
  parameter int STACK  = 16,
  parameter int OPCODE = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic [OPCODE-1:0]           i_opcode,
  input  logic [DATA-1:0]             i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_valid,
  output logic [DATA-1:0]             o_data,
  output logic [2:0]                  o_err,
  output logic [STACK-1:0][DATA-1:0]  d_stack,
  output logic [$clog2(STACK):0]      d_index
);

  localparam int AW = $clog2(STACK);
  localparam int IW = AW + 1;

  // Handshake: a command transfers on a rising edge where i_en, i_valid and o_ready
  // are all high; o_valid is a single-cycle pulse qualifying o_data and o_err.
  state_t                     state_q;
  logic [STACK-1:0][DATA-1:0] stack_q;
  logic [IW-1:0]              idx_q;
  logic                       mod_q;

  opcode_t         op;
  logic            op_known;
  logic [IW-1:0]   idx_p1, idx_m1, idx_m2, idx_m3;
  logic [AW-1:0]   i_new, i_top, i_sec, i_thd;
  logic [DATA-1:0] top, sec, thd;

  logic                       accept;
  logic [2:0]                 cmd_err;
  logic [DATA-1:0]            cmd_data;
  logic [STACK-1:0][DATA-1:0] nxt_stack;
  logic [IW-1:0]              nxt_idx;
  logic                       div_go;

  logic            div_busy;
  logic            div_done;
  logic [DATA-1:0] div_quo;
  logic [DATA-1:0] div_rem;

  assign op       = opcode_t'(i_opcode[3:0]);
  assign op_known = i_opcode <= OPCODE'(OP_LAST);

  assign idx_p1 = idx_q + IW'(1);
  assign idx_m1 = idx_q - IW'(1);
  assign idx_m2 = idx_q - IW'(2);
  assign idx_m3 = idx_q - IW'(3);
  assign i_new  = idx_q[AW-1:0];
  assign i_top  = idx_m1[AW-1:0];
  assign i_sec  = idx_m2[AW-1:0];
  assign i_thd  = idx_m3[AW-1:0];
  assign top    = stack_q[i_top];
  assign sec    = stack_q[i_sec];
  assign thd    = stack_q[i_thd];

  assign accept  = i_en && i_valid && o_ready && !div_busy;
  assign d_stack = stack_q;
  assign d_index = idx_q;

  // Error priority: unknown opcode, underflow, overflow, then divide-by-zero.
  always_comb begin
    cmd_err   = ERR_OK;
    cmd_data  = '0;
    nxt_stack = stack_q;
    nxt_idx   = idx_q;
    div_go    = 1'b0;
    if (!op_known) begin
      cmd_err = ERR_INVALID;
    end else if (idx_q < IW'(op_need(op))) begin
      cmd_err = ERR_UNDERFLOW;
    end else if (op_grows(op) && (idx_q == IW'(STACK))) begin
      cmd_err = ERR_OVERFLOW;
    end else if (((op == OP_DIV) || (op == OP_MOD)) && (top == '0)) begin
      cmd_err = ERR_DIV_ZERO;
    end else begin
      case (op)
        OP_PUSH: begin
          nxt_stack[i_new] = i_data;
          nxt_idx          = idx_p1;
        end
        OP_POP: begin
          cmd_data = top;
          nxt_idx  = idx_m1;
        end
        OP_ADD: begin
          nxt_stack[i_sec] = sec + top;
          nxt_idx          = idx_m1;
        end
        OP_SUB: begin
          nxt_stack[i_sec] = sec - top;
          nxt_idx          = idx_m1;
        end
        OP_MUL: begin
          nxt_stack[i_sec] = sec * top;
          nxt_idx          = idx_m1;
        end
        OP_DIV, OP_MOD: div_go = 1'b1;
        OP_DUP: begin
          nxt_stack[i_new] = top;
          nxt_idx          = idx_p1;
        end
        OP_ROT: begin
          nxt_stack[i_thd] = sec;
          nxt_stack[i_sec] = top;
          nxt_stack[i_top] = thd;
        end
        OP_SWAP: begin
          nxt_stack[i_sec] = top;
          nxt_stack[i_top] = sec;
        end
        OP_OVER: begin
          nxt_stack[i_new] = sec;
          nxt_idx          = idx_p1;
        end
        OP_DROP: nxt_idx = idx_m1;
        OP_DEPTH: begin
          nxt_stack[i_new] = DATA'(idx_q);
          cmd_data         = DATA'(idx_q);
          nxt_idx          = idx_p1;
        end
        default: ;
      endcase
    end
  end

  seq_divider #(.DATA(DATA)) u_div (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .en        (i_en),
    .start     (accept && div_go),
    .dividend  (sec),
    .divisor   (top),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      stack_q <= '0;
      idx_q   <= '0;
      mod_q   <= 1'b0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_err   <= ERR_OK;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            o_ready <= 1'b0;
            if (div_go) begin
              state_q <= ST_DIV;
              mod_q   <= (op == OP_MOD);
            end else begin
              state_q <= ST_RESP;
              stack_q <= nxt_stack;
              idx_q   <= nxt_idx;
              o_data  <= cmd_data;
              o_err   <= cmd_err;
              o_valid <= 1'b1;
            end
          end
        end
        // Divider results are consumed on the same edge as its last step.
        ST_DIV: begin
          if (div_done) begin
            stack_q[i_sec] <= mod_q ? div_rem : div_quo;
            idx_q          <= idx_m1;
            o_data         <= '0;
            o_err          <= ERR_OK;
            o_valid        <= 1'b1;
            state_q        <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: directed scenarios plus random commands, with expected responses
// from a queue-based stack model checked by an independent output monitor.
module tb_stack_engine;
  import stack_engine_pkg::*;

  localparam int DATA   = 32;
  localparam int STACK  = 16;
  localparam int OPCODE = 16;
  localparam int IW     = $clog2(STACK) + 1;

  logic                       clk;
  logic                       rst;
  logic                       en;
  logic [OPCODE-1:0]          opcode;
  logic [DATA-1:0]            data;
  logic                       valid;
  logic                       ready;
  logic                       out_valid;
  logic [DATA-1:0]            out_data;
  logic [2:0]                 out_err;
  logic [STACK-1:0][DATA-1:0] dstk;
  logic [IW-1:0]              didx;

  typedef struct packed {
    logic [DATA-1:0]            data;
    logic [2:0]                 err;
    logic [IW-1:0]              depth;
    logic [STACK-1:0][DATA-1:0] stk;
    int unsigned                due;
  } exp_t;

  exp_t            exp_q[$];
  logic [DATA-1:0] model[$];
  int unsigned     cyc = 0;
  int unsigned     n_checks = 0;
  int unsigned     n_pass = 0;
  int unsigned     n_valid = 0;

  stack_engine #(.DATA(DATA), .STACK(STACK), .OPCODE(OPCODE)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_opcode (opcode),
    .i_data   (data),
    .i_valid  (valid),
    .o_ready  (ready),
    .o_valid  (out_valid),
    .o_data   (out_data),
    .o_err    (out_err),
    .d_stack  (dstk),
    .d_index  (didx)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: apply one command to the model stack and build the expected response.
  task automatic model_apply(input logic [OPCODE-1:0] opc, input logic [DATA-1:0] val,
                             output exp_t e);
    int d, need;
    logic grows;
    logic [DATA-1:0] a, b, c;
    d = model.size();
    e = '0;
    case (opc)
      2, 7, 11:               need = 1;
      3, 4, 5, 6, 9, 10, 13:  need = 2;
      8:                      need = 3;
      default:                need = 0;
    endcase
    grows = (opc == 1) || (opc == 7) || (opc == 10) || (opc == 12);
    if (opc > 13) e.err = 3'd1;
    else if (d < need) e.err = 3'd2;
    else if (grows && d == STACK) e.err = 3'd3;
    else if ((opc == 6 || opc == 13) && model[d-1] == 0) e.err = 3'd4;
    else begin
      case (opc)
        1: model.push_back(val);
        2: e.data = model.pop_back();
        3, 4, 5, 6, 13: begin
          b = model.pop_back();
          a = model.pop_back();
          case (opc)
            3: c = a + b;
            4: c = a - b;
            5: c = a * b;
            6: c = a / b;
            default: c = a % b;
          endcase
          model.push_back(c);
          if (opc == 6 || opc == 13) e.due = DATA;
        end
        7: model.push_back(model[d-1]);
        8: begin
          c = model.pop_back();
          b = model.pop_back();
          a = model.pop_back();
          model.push_back(b);
          model.push_back(c);
          model.push_back(a);
        end
        9: begin
          c = model.pop_back();
          b = model.pop_back();
          model.push_back(c);
          model.push_back(b);
        end
        10: model.push_back(model[d-2]);
        11: void'(model.pop_back());
        12: begin
          e.data = DATA'(d);
          model.push_back(DATA'(d));
        end
        default: ;
      endcase
    end
    e.depth = IW'(model.size());
    for (int i = 0; i < model.size(); i++) e.stk[i] = model[i];
  endtask

  // Driver: wait for ready, present one command, record its expected response.
  // gap > 0 drops i_en for that many cycles shortly after acceptance (divides only).
  task automatic issue(input logic [OPCODE-1:0] opc, input logic [DATA-1:0] val, input int gap);
    exp_t e;
    int   budget;
    budget = 0;
    @(negedge clk);
    while (!ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    opcode = opc;
    data   = val;
    valid  = 1'b1;
    @(posedge clk);
    #1;
    valid  = 1'b0;
    opcode = OPCODE'($urandom());
    data   = $urandom();
    model_apply(opc, val, e);
    e.due = e.due + cyc + gap;
    exp_q.push_back(e);
    if (gap > 0) begin
      repeat (3) @(negedge clk);
      en = 1'b0;
      repeat (gap) @(negedge clk);
      en = 1'b1;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || !ready) && b < 400) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0 || !ready) check("drain_timeout", 0, 1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    logic ok;
    if (!rst && out_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc, e.due);
        check("o_data", out_data, e.data);
        check("o_err", out_err, e.err);
        check("d_index", didx, e.depth);
        ok = 1'b1;
        for (int i = 0; i < STACK; i++)
          if (i < e.depth && dstk[i] !== e.stk[i]) ok = 1'b0;
        check("d_stack", ok, 1);
      end
    end
  end

  initial begin : stimulus
    int unsigned v0;
    int unsigned r;
    logic [OPCODE-1:0] opc;
    logic [DATA-1:0]   val;
    rst = 1'b1;
    en = 1'b1;
    valid = 1'b0;
    opcode = '0;
    data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_err", out_err, 0);
    check("rst_index", didx, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", ready, 1);

    // Arithmetic and pop
    issue(1, 7, 0); issue(1, 5, 0); issue(4, 0, 0); issue(2, 0, 0);
    drain();
    check("sub_pop_data", out_data, 2);
    check("sub_pop_err", out_err, 0);
    check("sub_pop_index", didx, 0);

    // Divide and modulo
    issue(1, 100, 0); issue(1, 7, 0); issue(6, 0, 0);
    drain();
    check("div_top", dstk[0], 14);
    check("div_index", didx, 1);
    issue(2, 0, 0);
    issue(1, 100, 0); issue(1, 7, 0); issue(13, 0, 0);
    drain();
    check("mod_top", dstk[0], 2);
    issue(2, 0, 0);

    // Underflow and divide-by-zero
    issue(2, 0, 0);
    drain();
    check("pop_empty_err", out_err, 2);
    check("pop_empty_index", didx, 0);
    issue(1, 5, 0); issue(1, 0, 0); issue(6, 0, 0);
    drain();
    check("div0_err", out_err, 4);
    check("div0_index", didx, 2);
    issue(11, 0, 0); issue(11, 0, 0);

    // Overflow at full depth
    for (int i = 0; i < STACK; i++) issue(1, DATA'(100 + i), 0);
    issue(1, 999, 0);
    drain();
    check("ovf_err", out_err, 3);
    check("ovf_index", didx, 16);
    check("ovf_entry15", dstk[15], 115);
    issue(12, 0, 0);
    drain();
    check("depth_full_err", out_err, 3);
    for (int i = 0; i < STACK; i++) issue(11, 0, 0);

    // ROT / SWAP / OVER
    issue(1, 1, 0); issue(1, 2, 0); issue(1, 3, 0); issue(8, 0, 0);
    drain();
    check("rot_0", dstk[0], 2); check("rot_1", dstk[1], 3); check("rot_2", dstk[2], 1);
    issue(9, 0, 0);
    drain();
    check("swap_1", dstk[1], 1); check("swap_2", dstk[2], 3);
    issue(10, 0, 0);
    drain();
    check("over_index", didx, 4);
    check("over_top", dstk[3], 1);
    for (int i = 0; i < 4; i++) issue(11, 0, 0);

    // Enable low freezes a divide; enable low blocks acceptance
    issue(1, 100, 0); issue(1, 7, 0); issue(6, 0, 5);
    drain();
    check("div_gap_top", dstk[0], 14);
    issue(11, 0, 0);
    drain();
    @(negedge clk);
    en = 1'b0; opcode = 1; data = 55; valid = 1'b1;
    repeat (4) @(negedge clk);
    valid = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    check("en_low_index", didx, 0);

    // Random commands
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 25) opc = 1;
      else if (r < 30) opc = OPCODE'($urandom_range(14, 65535));
      else opc = OPCODE'($urandom_range(0, 13));
      val = $urandom_range(0, 1) ? DATA'($urandom_range(0, 20)) : $urandom();
      issue(opc, val, 0);
    end
    drain();

    // Reset during a divide
    while (model.size() > 0) issue(11, 0, 0);
    issue(1, 50, 0); issue(1, 3, 0);
    drain();
    @(negedge clk);
    opcode = 6; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_div_ready", ready, 0);
    rst = 1'b1;
    #1;
    exp_q.delete();
    model.delete();
    check("mrst_valid", out_valid, 0);
    check("mrst_data", out_data, 0);
    check("mrst_err", out_err, 0);
    check("mrst_index", didx, 0);
    check("mrst_stack", dstk == '0, 1);
    v0 = n_valid;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_ready", ready, 1);
    repeat (40) @(negedge clk);
    check("mrst_no_valid", n_valid, v0);
    issue(1, 9, 0); issue(2, 0, 0);
    drain();
    check("post_rst_pop", out_data, 9);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
